pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the RV32 core. It arbitrates every request that redirects or stalls instruction fetch: EX-stage jumps, load-use hazards, multi-cycle divide stalls, trap entry and mret. It drives the fetch stage's jump_flag/jump_addr/hold and the ID/EX flush and hold controls. It also sequences the two-step trap entry: CSR save, then vector jump.

Parameters:
ADDR_W, 12, PC/address width; must equal the fetch-stage pc width
DIV_CYCLES, 8, total pipeline-hold cycles per divide (must be >= 2)
CAUSE_W, 4, width of the trap cause code

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
ex_jump_req  input  1  EX-stage branch/jal taken this cycle
ex_jump_addr  input  ADDR_W  EX-stage jump target
ld_use_hazard  input  1  ID detects load-use dependency this cycle
div_start  input  1  EX starts a divide this cycle (1-cycle pulse)
trap_req  input  1  trap request; level, held by requester until trap_ack
trap_pc  input  ADDR_W  pc of the trapping instruction
trap_cause  input  CAUSE_W  trap cause code
mret_req  input  1  EX executes mret this cycle
mtvec_i  input  ADDR_W  current mtvec value
mepc_i  input  ADDR_W  current mepc value
jump_flag  output  1  redirect fetch this cycle
jump_addr  output  ADDR_W  fetch redirect target, bits [1:0] forced 0
hold_if  output  1  hold fetch pc
hold_id  output  1  hold IF/ID register
hold_ex  output  1  hold ID/EX register
flush_id  output  1  clear IF/ID register to NOP
flush_ex  output  1  clear ID/EX register to NOP
mepc_we  output  1  write mepc
mepc_wdata  output  ADDR_W  mepc write data
mcause_we  output  1  write mcause
mcause_wdata  output  CAUSE_W  mcause write data
trap_ack  output  1  1-cycle pulse; trap sequence completes
div_done  output  1  1-cycle pulse on the last divide-hold cycle
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, DIV_WAIT, TRAP_SAVE, TRAP_JUMP. The state register, divide counter and latched trap_pc/trap_cause are clocked. All outputs are combinational from the state, registers and inputs (Mealy), so a jump reaches fetch at the next clock edge.
- Reset (async): state=IDLE, counter=0, latches=0. While rst is high, all outputs are 0. Reset mid-sequence aborts it; no partial CSR write follows reset release.
- IDLE priority, highest first: trap_req > mret_req > ex_jump_req > div_start > ld_use_hazard. Only the winning request's outputs are asserted.
- trap_req: latch trap_pc and trap_cause; hold_if=hold_id=hold_ex=1, flush_id=flush_ex=1; next state TRAP_SAVE.
- TRAP_SAVE: mepc_we=1 with mepc_wdata=latched pc (bits [1:0] zero). mcause_we=1 with mcause_wdata=latched cause. All holds=1. Next state TRAP_JUMP.
- TRAP_JUMP: jump_flag=1, jump_addr=mtvec_i, flush_id=flush_ex=1, trap_ack=1. Next state IDLE.
- mret_req: jump_flag=1, jump_addr=mepc_i, flush_id=flush_ex=1; stay IDLE.
- ex_jump_req: jump_flag=1, jump_addr=ex_jump_addr&~3, flush_id=flush_ex=1; stay IDLE.
- jump_flag overrides hold at fetch, so hold_if=0 whenever jump_flag=1.
- div_start: hold_if=hold_id=hold_ex=1; counter<=DIV_CYCLES-2; next state DIV_WAIT.
- DIV_WAIT: all holds=1; counter decrements each cycle. When counter==0: div_done=1 and next state IDLE. Total hold cycles including the start cycle = DIV_CYCLES.
- ld_use_hazard: hold_if=hold_id=1, flush_ex=1 (one bubble), hold_ex=0; stay IDLE.
- Outside IDLE, all requests are ignored. trap_req stays pending because it is a level signal and is taken on the first IDLE cycle. Pulse requests (ex_jump_req, mret_req, div_start, ld_use_hazard) cannot legally occur outside IDLE because EX/ID are held or flushed. The bench flags them as errors.
- No request in IDLE: all outputs 0.

Test Plan:
- Reset and idle: assert rst mid-cycle -> all outputs 0 immediately. Release rst with no requests -> outputs stay 0, busy=0.
- Jump: ex_jump_req=1, ex_jump_addr=0x0A6 -> same cycle jump_flag=1, jump_addr=0x0A4, flush_id=flush_ex=1, hold_if=0.
- Divide with DIV_CYCLES=8: div_start pulse -> hold_if/id/ex=1 for exactly 8 consecutive cycles, div_done=1 only on the 8th, busy=1 on cycles 2-8.
- Trap: trap_req=1, trap_pc=0x124, trap_cause=0xB, mtvec_i=0x200 -> cycle0 holds and flushes. Cycle1: mepc_we=1 with 0x124 and mcause_we=1 with 0xB. Cycle2: jump_flag=1, jump_addr=0x200, trap_ack=1. Cycle3: IDLE.
- Priority: trap_req, mret_req and ex_jump_req all high in one cycle -> trap sequence taken, no jump that cycle. Then trap_req asserted during DIV_WAIT -> deferred until the divide finishes, then the trap runs.
- Abort: assert rst in TRAP_SAVE -> no mepc_we after release, state IDLE; ld_use_hazard afterwards -> hold_if=hold_id=1, flush_ex=1 for one cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - RV32 pipeline sequencer: fetch redirect, stalls, flushes and two-step trap entry
module pipe_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DIV_CYCLES = 8,
  parameter int CAUSE_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_jump_req,
  input  logic [ADDR_W-1:0]  ex_jump_addr,
  input  logic               ld_use_hazard,
  input  logic               div_start,
  input  logic               trap_req,
  input  logic [ADDR_W-1:0]  trap_pc,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic               mret_req,
  input  logic [ADDR_W-1:0]  mtvec_i,
  input  logic [ADDR_W-1:0]  mepc_i,
  output logic               jump_flag,
  output logic [ADDR_W-1:0]  jump_addr,
  output logic               hold_if,
  output logic               hold_id,
  output logic               hold_ex,
  output logic               flush_id,
  output logic               flush_ex,
  output logic               mepc_we,
  output logic [ADDR_W-1:0]  mepc_wdata,
  output logic               mcause_we,
  output logic [CAUSE_W-1:0] mcause_wdata,
  output logic               trap_ack,
  output logic               div_done,
  output logic               busy
);

  // Counter only has to hold DIV_CYCLES-2; keep at least one bit for DIV_CYCLES==2.
  localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV_WAIT  = 2'd1,
    TRAP_SAVE = 2'd2,
    TRAP_JUMP = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   div_cnt;
  logic [ADDR_W-1:0]  trap_pc_q;
  logic [CAUSE_W-1:0] trap_cause_q;

  // Sequencer state, divide countdown and trap latches; requests only accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      trap_pc_q    <= '0;
      trap_cause_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_req) begin
            trap_pc_q    <= trap_pc;
            trap_cause_q <= trap_cause;
            state        <= TRAP_SAVE;
          end else if (!mret_req && !ex_jump_req && div_start) begin
            // The start cycle is the first hold cycle, so count the rest down to zero.
            div_cnt <= CNT_W'(DIV_CYCLES - 2);
            state   <= DIV_WAIT;
          end
        end
        DIV_WAIT: begin
          if (div_cnt == '0) begin
            state <= IDLE;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        TRAP_SAVE: state <= TRAP_JUMP;
        TRAP_JUMP: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Mealy control outputs so a redirect reaches fetch on the very next edge; forced quiet in reset.
  always_comb begin
    jump_flag    = 1'b0;
    jump_addr    = '0;
    hold_if      = 1'b0;
    hold_id      = 1'b0;
    hold_ex      = 1'b0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    mepc_we      = 1'b0;
    mepc_wdata   = '0;
    mcause_we    = 1'b0;
    mcause_wdata = '0;
    trap_ack     = 1'b0;
    div_done     = 1'b0;
    busy         = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (trap_req) begin
            hold_if  = 1'b1;
            hold_id  = 1'b1;
            hold_ex  = 1'b1;
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (mret_req) begin
            jump_flag = 1'b1;
            jump_addr = mepc_i & ALIGN_MASK;
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
          end else if (ex_jump_req) begin
            jump_flag = 1'b1;
            jump_addr = ex_jump_addr & ALIGN_MASK;
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
          end else if (div_start) begin
            hold_if = 1'b1;
            hold_id = 1'b1;
            hold_ex = 1'b1;
          end else if (ld_use_hazard) begin
            // Freeze IF/ID and inject one bubble into EX.
            hold_if  = 1'b1;
            hold_id  = 1'b1;
            flush_ex = 1'b1;
          end
        end
        DIV_WAIT: begin
          hold_if  = 1'b1;
          hold_id  = 1'b1;
          hold_ex  = 1'b1;
          div_done = (div_cnt == '0);
        end
        TRAP_SAVE: begin
          hold_if      = 1'b1;
          hold_id      = 1'b1;
          hold_ex      = 1'b1;
          mepc_we      = 1'b1;
          mepc_wdata   = trap_pc_q & ALIGN_MASK;
          mcause_we    = 1'b1;
          mcause_wdata = trap_cause_q;
        end
        TRAP_JUMP: begin
          // Jump wins over hold at fetch, so hold_if stays low here.
          jump_flag = 1'b1;
          jump_addr = mtvec_i & ALIGN_MASK;
          flush_id  = 1'b1;
          flush_ex  = 1'b1;
          trap_ack  = 1'b1;
        end
        default: begin
          busy = 1'b1;
        end
      endcase
    end
  end

endmodule
